// File: rtl/pipe_step_ctrl.sv
// rtl/pipe_step_ctrl.sv - debug run/step/halt controller driving the pipeline-wide register enable
module pipe_step_ctrl #(
  parameter int STEP_W = 8,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd,
  input  logic [STEP_W-1:0] step_n,
  input  logic              halt_retired,
  output logic              pipe_en,
  output logic [1:0]        state,
  output logic [STEP_W-1:0] steps_left,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10,
    S_END  = 2'b11
  } state_t;

  localparam logic [1:0] CMD_RUN  = 2'b01;
  localparam logic [1:0] CMD_STEP = 2'b10;
  localparam logic [1:0] CMD_HALT = 2'b11;

  localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  state_t cur;

  logic is_run;
  logic is_step;
  logic is_halt;
  logic step_zero;

  // commands are only meaningful in the cycle cmd_valid qualifies them
  assign is_run    = cmd_valid && (cmd == CMD_RUN);
  assign is_step   = cmd_valid && (cmd == CMD_STEP);
  assign is_halt   = cmd_valid && (cmd == CMD_HALT);
  assign step_zero = (step_n == '0);

  assign state = cur;

  // control FSM; retire of HALT beats a halt command, which beats step expiry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur        <= S_IDLE;
      pipe_en    <= 1'b0;
      steps_left <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (cur)
        S_IDLE: begin
          if (is_run) begin
            cur     <= S_RUN;
            pipe_en <= 1'b1;
          end else if (is_step) begin
            if (step_zero) begin
              // an empty step finishes at once without enabling the pipe
              done <= 1'b1;
            end else begin
              cur        <= S_STEP;
              pipe_en    <= 1'b1;
              steps_left <= step_n;
            end
          end
        end
        S_RUN: begin
          if (halt_retired) begin
            cur     <= S_END;
            pipe_en <= 1'b0;
            done    <= 1'b1;
          end else if (is_halt) begin
            cur     <= S_IDLE;
            pipe_en <= 1'b0;
            done    <= 1'b1;
          end
        end
        S_STEP: begin
          if (halt_retired) begin
            cur        <= S_END;
            pipe_en    <= 1'b0;
            steps_left <= '0;
            done       <= 1'b1;
          end else if (is_halt || (steps_left == STEP_ONE)) begin
            cur        <= S_IDLE;
            pipe_en    <= 1'b0;
            steps_left <= '0;
            done       <= 1'b1;
          end else begin
            steps_left <= steps_left - STEP_ONE;
          end
        end
        S_END: begin
          // terminal until reset: the program has executed HALT
          pipe_en <= 1'b0;
        end
        default: begin
          cur     <= S_IDLE;
          pipe_en <= 1'b0;
        end
      endcase
    end
  end

  // count enabled edges, holding at all-ones rather than wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
    end else if (pipe_en && (cycle_cnt != CNT_MAX)) begin
      cycle_cnt <= cycle_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_step_ctrl.sv
// tb/tb_pipe_step_ctrl.sv - scoreboard bench for pipe_step_ctrl with a behavioural reference model
module tb_pipe_step_ctrl;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_STEP = 2;
  localparam int M_END  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic [7:0] step_n = 8'd0;
  logic       halt_retired = 1'b0;

  logic        pipe_en;
  logic [1:0]  state;
  logic [7:0]  steps_left;
  logic [31:0] cycle_cnt;
  logic        done;

  logic        pipe_en_s;
  logic [1:0]  state_s;
  logic [7:0]  steps_left_s;
  logic [3:0]  cycle_cnt_s;
  logic        done_s;

  int compared = 0;
  int mismatched = 0;

  pipe_step_ctrl #(.STEP_W(8), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd), .step_n(step_n),
    .halt_retired(halt_retired), .pipe_en(pipe_en), .state(state),
    .steps_left(steps_left), .cycle_cnt(cycle_cnt), .done(done)
  );

  pipe_step_ctrl #(.STEP_W(8), .CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd), .step_n(step_n),
    .halt_retired(halt_retired), .pipe_en(pipe_en_s), .state(state_s),
    .steps_left(steps_left_s), .cycle_cnt(cycle_cnt_s), .done(done_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [1:0]  st;
    logic [7:0]  sl;
    logic [31:0] c32;
    logic [3:0]  c4;
    logic        dn;
  } exp_t;

  exp_t exp_q[$];

  // reference model: mode, steps still owed, total enabled edges, stop event
  int     m_mode = M_IDLE;
  int     m_rem = 0;
  longint m_total = 0;
  bit     m_done = 1'b0;

  function automatic exp_t snapshot();
    exp_t e;
    e.en  = (m_mode == M_RUN) || (m_mode == M_STEP);
    e.st  = 2'(m_mode);
    e.sl  = 8'(m_rem);
    e.c32 = (m_total > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(m_total);
    e.c4  = (m_total > 15) ? 4'd15 : 4'(m_total);
    e.dn  = m_done;
    return e;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_rem = 0; m_total = 0; m_done = 1'b0;
  endtask

  task automatic model_step(input bit v, input bit [1:0] c, input int n, input bit hr);
    bit running;
    bit want_run, want_step, want_halt;
    running   = (m_mode == M_RUN) || (m_mode == M_STEP);
    want_run  = v && (c == 2'd1);
    want_step = v && (c == 2'd2);
    want_halt = v && (c == 2'd3);
    if (running) m_total++;
    m_done = 1'b0;
    if (running && hr) begin
      m_mode = M_END; m_rem = 0; m_done = 1'b1;
    end else if (running && want_halt) begin
      m_mode = M_IDLE; m_rem = 0; m_done = 1'b1;
    end else if (m_mode == M_STEP) begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        m_mode = M_IDLE; m_done = 1'b1;
      end
    end else if (m_mode == M_IDLE && want_run) begin
      m_mode = M_RUN;
    end else if (m_mode == M_IDLE && want_step) begin
      if (n == 0) m_done = 1'b1;
      else begin
        m_mode = M_STEP; m_rem = n;
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // monitor: outputs are valid every cycle, so pop one expectation per edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pipe_en", {63'd0, pipe_en}, {63'd0, e.en});
      chk("state", {62'd0, state}, {62'd0, e.st});
      chk("steps_left", {56'd0, steps_left}, {56'd0, e.sl});
      chk("cycle_cnt", {32'd0, cycle_cnt}, {32'd0, e.c32});
      chk("done", {63'd0, done}, {63'd0, e.dn});
      chk("pipe_en_w4", {63'd0, pipe_en_s}, {63'd0, e.en});
      chk("state_w4", {62'd0, state_s}, {62'd0, e.st});
      chk("cycle_cnt_w4", {60'd0, cycle_cnt_s}, {60'd0, e.c4});
    end
  end

  task automatic cyc(input bit v, input bit [1:0] c, input int n, input bit hr);
    @(negedge clk);
    cmd_valid    = v;
    cmd          = c;
    step_n       = 8'(n);
    halt_retired = hr;
    model_step(v, c, n, hr);
    exp_q.push_back(snapshot());
  endtask

  task automatic nops(input int k);
    for (int i = 0; i < k; i++) cyc(1'b0, 2'($urandom), int'($urandom_range(0, 255)), 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    cmd_valid = 1'b0;
    halt_retired = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pipe_en_async", {63'd0, pipe_en}, 64'd0);
    chk("rst_state", {62'd0, state}, 64'd0);
    chk("rst_steps_left", {56'd0, steps_left}, 64'd0);
    chk("rst_cycle_cnt", {32'd0, cycle_cnt}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    model_reset();
    exp_q.push_back(snapshot());
    @(negedge clk);
    rst_n = 1'b1;
    model_step(1'b0, 2'd0, 0, 1'b0);
    exp_q.push_back(snapshot());
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
  endtask

  initial begin
    #1_000_000;
    mismatched++;
    $display("FAIL watchdog: simulation time limit reached");
    summary();
    $finish;
  end

  initial begin
    do_reset();

    // step 10 interrupted by asynchronous reset
    cyc(1'b1, 2'd2, 10, 1'b0);
    nops(4);
    do_reset();

    // step 3, then an empty step
    cyc(1'b1, 2'd2, 3, 1'b0);
    nops(5);
    cyc(1'b1, 2'd2, 0, 1'b0);
    nops(3);

    // run, ignored run/step while running, then halt
    cyc(1'b1, 2'd1, 0, 1'b0);
    nops(5);
    cyc(1'b1, 2'd1, 0, 1'b0);
    nops(5);
    cyc(1'b1, 2'd2, 7, 1'b0);
    nops(8);
    cyc(1'b1, 2'd3, 0, 1'b0);
    nops(3);

    // HALT retire coinciding with a halt command
    do_reset();
    cyc(1'b1, 2'd1, 0, 1'b0);
    nops(3);
    cyc(1'b1, 2'd3, 0, 1'b1);
    cyc(1'b1, 2'd1, 0, 1'b0);
    cyc(1'b1, 2'd2, 4, 1'b0);
    nops(3);

    // step 5 with HALT retiring on its last enabled cycle
    do_reset();
    cyc(1'b1, 2'd2, 5, 1'b0);
    nops(4);
    cyc(1'b0, 2'd0, 0, 1'b1);
    nops(3);

    // long run past the 4-bit counter limit, then halt
    do_reset();
    cyc(1'b1, 2'd1, 0, 1'b0);
    nops(20);
    cyc(1'b1, 2'd3, 0, 1'b0);
    nops(2);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      if ((m_mode == M_END && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        bit v;
        int n;
        v = ($urandom_range(0, 2) == 0);
        n = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 6));
        cyc(v, 2'($urandom), n, $urandom_range(0, 31) == 0);
      end
    end

    @(negedge clk);
    cmd_valid = 1'b0;
    halt_retired = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    summary();
    $finish;
  end

endmodule
